// File: rtl/temp_reg_load_arbiter_if.sv
// Handshake and load-strobe bundle between the PIM/MOV requesters and temp_reg_load_arbiter.
// The master side is the requester pair; the slave side is the arbiter.
`timescale 1ns/1ps
interface temp_reg_load_arbiter_if #(
  parameter int N      = 10,
  parameter int NREG   = 4,
  parameter int ADDR_W = 2
);
  logic              pim_valid;
  logic [ADDR_W-1:0] pim_addr;
  logic [N-1:0]      pim_data;
  logic              pim_ready;
  logic              mov_valid;
  logic [ADDR_W-1:0] mov_addr;
  logic [N-1:0]      mov_data;
  logic              mov_ready;
  logic [NREG-1:0]   pim_load;
  logic [NREG-1:0]   mov_load;
  logic [N-1:0]      d_out;
  logic [N-1:0]      mov_out;
  logic              addr_err;

  modport master (
    output pim_valid, pim_addr, pim_data, mov_valid, mov_addr, mov_data,
    input  pim_ready, mov_ready, pim_load, mov_load, d_out, mov_out, addr_err
  );

  modport slave (
    input  pim_valid, pim_addr, pim_data, mov_valid, mov_addr, mov_data,
    output pim_ready, mov_ready, pim_load, mov_load, d_out, mov_out, addr_err
  );
endinterface

// File: rtl/temp_reg_load_arbiter.sv
// Write arbiter for the temp_reg bank: PIM wins same-register conflicts unless MOV has starved.
// Optional macro TEMP_REG_ARB_STATS_EN adds a saturating 16-bit conflict_cnt output.
`timescale 1ns/1ps
module temp_reg_load_arbiter #(
  parameter int N          = 10,
  parameter int NREG       = 4,
  parameter int ADDR_W     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  temp_reg_load_arbiter_if.slave   bus
`ifdef TEMP_REG_ARB_STATS_EN
  ,
  output logic [15:0]              conflict_cnt
`endif
);

  typedef enum logic {PIM_PRI, MOV_PRI} state_t;

  localparam int                CNT_W     = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W:0]   LP_NREG   = (ADDR_W + 1)'(NREG);
  localparam logic [CNT_W-1:0]  LP_STARVE = CNT_W'(STARVE_MAX);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_next_cnt;

  logic              w_pim_in_range;
  logic              w_mov_in_range;
  logic              w_conflict;
  logic              w_pim_ready;
  logic              w_mov_ready;
  logic [NREG-1:0]   w_pim_onehot;
  logic [NREG-1:0]   w_mov_onehot;

  logic [NREG-1:0]   r_pim_load;
  logic [NREG-1:0]   r_mov_load;
  logic [N-1:0]      r_d_out;
  logic [N-1:0]      r_mov_out;
  logic              r_addr_err;

  // Out-of-range targets never conflict; they are simply consumed and flagged.
  assign w_pim_in_range = ({1'b0, bus.pim_addr} < LP_NREG);
  assign w_mov_in_range = ({1'b0, bus.mov_addr} < LP_NREG);
  assign w_conflict     = bus.pim_valid && bus.mov_valid &&
                          (bus.pim_addr == bus.mov_addr) && w_pim_in_range;
  assign w_pim_onehot   = NREG'(1) << bus.pim_addr;
  assign w_mov_onehot   = NREG'(1) << bus.mov_addr;

  always_comb begin
    w_pim_ready  = 1'b0;
    w_mov_ready  = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_starve_cnt;
    if (rst_n) begin
      w_pim_ready = bus.pim_valid && !(w_conflict && (r_state == MOV_PRI));
      w_mov_ready = bus.mov_valid && !(w_conflict && (r_state == PIM_PRI));
    end
    if (w_mov_ready) begin
      w_next_cnt = '0;
    end else if (bus.mov_valid && (r_starve_cnt < LP_STARVE)) begin
      w_next_cnt = r_starve_cnt + 1'b1;
    end
    case (r_state)
      PIM_PRI: if (w_next_cnt >= LP_STARVE) w_next_state = MOV_PRI;
      MOV_PRI: if (w_mov_ready)             w_next_state = PIM_PRI;
      default:                              w_next_state = PIM_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PIM_PRI;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_starve_cnt <= w_next_cnt;
    end
  end

  // Data registers only follow in-range transfers so they hold the last loaded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pim_load <= '0;
      r_mov_load <= '0;
      r_d_out    <= '0;
      r_mov_out  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_pim_load <= (w_pim_ready && w_pim_in_range) ? w_pim_onehot : '0;
      r_mov_load <= (w_mov_ready && w_mov_in_range) ? w_mov_onehot : '0;
      if (w_pim_ready && w_pim_in_range) r_d_out   <= bus.pim_data;
      if (w_mov_ready && w_mov_in_range) r_mov_out <= bus.mov_data;
      r_addr_err <= (w_pim_ready && !w_pim_in_range) ||
                    (w_mov_ready && !w_mov_in_range);
    end
  end

  assign bus.pim_ready = w_pim_ready;
  assign bus.mov_ready = w_mov_ready;
  assign bus.pim_load  = r_pim_load;
  assign bus.mov_load  = r_mov_load;
  assign bus.d_out     = r_d_out;
  assign bus.mov_out   = r_mov_out;
  assign bus.addr_err  = r_addr_err;

`ifdef TEMP_REG_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (w_conflict && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`else
  // Conflict statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_temp_reg_load_arbiter.sv
// Directed-vector bench for temp_reg_load_arbiter (NREG=3 so out-of-range addresses exist).
// A driver queues each vector's expectations; an independent monitor pops and compares every cycle.
`timescale 1ns/1ps
module tb_temp_reg_load_arbiter;

   localparam int N          = 10;
   localparam int NREG       = 3;
   localparam int ADDR_W     = 2;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   int compCount = 0;
   int failCount = 0;
   int cycleIdx  = 0;
   int modelCnt  = 0;

   temp_reg_load_arbiter_if #(.N(N), .NREG(NREG), .ADDR_W(ADDR_W)) bus ();

`ifdef TEMP_REG_ARB_STATS_EN
   logic [15:0] conflictCnt;
`endif

   temp_reg_load_arbiter #(
      .N(N), .NREG(NREG), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef TEMP_REG_ARB_STATS_EN
      ,
      .conflict_cnt (conflictCnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       pv;
      logic [1:0] pa;
      logic [9:0] pd;
      logic       mv;
      logic [1:0] ma;
      logic [9:0] md;
      logic       pr;
      logic       mr;
      logic [2:0] pl;
      logic [2:0] ml;
      logic [9:0] dout;
      logic [9:0] mout;
      logic       err;
      int         cc;
   } vec_t;

   vec_t vecs[$];
   vec_t scoreboard[$];

   function automatic vec_t mk(logic rst, logic pv, logic [1:0] pa, logic [9:0] pd,
                               logic mv, logic [1:0] ma, logic [9:0] md,
                               logic pr, logic mr, logic [2:0] pl, logic [2:0] ml,
                               logic [9:0] dout, logic [9:0] mout, logic err);
      vec_t v;
      v.rst = rst;  v.pv = pv;  v.pa = pa;  v.pd = pd;
      v.mv = mv;    v.ma = ma;  v.md = md;
      v.pr = pr;    v.mr = mr;  v.pl = pl;  v.ml = ml;
      v.dout = dout; v.mout = mout; v.err = err; v.cc = 0;
      return v;
   endfunction

   // Drives one vector and queues its expectations, tracking the expected conflict count.
   task automatic applyStimulus(input vec_t v);
      vec_t e;
      e = v;
      rst_n         = v.rst;
      bus.pim_valid = v.pv;
      bus.pim_addr  = v.pa;
      bus.pim_data  = v.pd;
      bus.mov_valid = v.mv;
      bus.mov_addr  = v.ma;
      bus.mov_data  = v.md;
      if (!v.rst) modelCnt = 0;
      e.cc = modelCnt;
      if (v.rst && v.pv && v.mv && (v.pa == v.ma) && (v.pa < 2'd3) && (modelCnt < 65535))
         modelCnt = modelCnt + 1;
      scoreboard.push_back(e);
   endtask

   // Records one comparison and reports it if the DUT value differs.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cycleIdx, act, exp);
      end
   endtask

   // Monitor: samples mid-cycle, after inputs settle and well clear of the rising edge.
   initial begin
      vec_t e;
      forever begin
         @(negedge clk);
         #3;
         if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput("pim_ready", 32'(bus.pim_ready), 32'(e.pr));
            checkOutput("mov_ready", 32'(bus.mov_ready), 32'(e.mr));
            checkOutput("pim_load",  32'(bus.pim_load),  32'(e.pl));
            checkOutput("mov_load",  32'(bus.mov_load),  32'(e.ml));
            checkOutput("d_out",     32'(bus.d_out),     32'(e.dout));
            checkOutput("mov_out",   32'(bus.mov_out),   32'(e.mout));
            checkOutput("addr_err",  32'(bus.addr_err),  32'(e.err));
            checkOutput("collision", 32'(bus.pim_load & bus.mov_load), 32'd0);
`ifdef TEMP_REG_ARB_STATS_EN
            checkOutput("conflict_cnt", 32'(conflictCnt), 32'(e.cc));
`endif
            cycleIdx++;
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waitCycles;
      bus.pim_valid = 1'b0; bus.pim_addr = '0; bus.pim_data = '0;
      bus.mov_valid = 1'b0; bus.mov_addr = '0; bus.mov_data = '0;
      #1 rst_n = 1'b0;

      //               rst pv pa  pd       mv ma  md      | pr mr pl      ml      dout     mout     err
      // Reset with both requesting, then release with distinct targets.
      vecs.push_back(mk(0, 1, 1, 10'h111, 1, 1, 10'h0AA, 0, 0, 3'b000, 3'b000, 10'h000, 10'h000, 0));
      vecs.push_back(mk(0, 1, 0, 10'h111, 1, 1, 10'h0AA, 0, 0, 3'b000, 3'b000, 10'h000, 10'h000, 0));
      vecs.push_back(mk(1, 1, 0, 10'h111, 1, 1, 10'h0AA, 1, 1, 3'b000, 3'b000, 10'h000, 10'h000, 0));
      // Simultaneous non-conflicting writes.
      vecs.push_back(mk(1, 1, 1, 10'h155, 1, 2, 10'h0AA, 1, 1, 3'b001, 3'b010, 10'h111, 10'h0AA, 0));
      vecs.push_back(mk(1, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 3'b010, 3'b100, 10'h155, 10'h0AA, 0));
      // Continuous conflict on reg 2: four PIM grants, then one MOV grant, then PIM again.
      vecs.push_back(mk(1, 1, 2, 10'h101, 1, 2, 10'h202, 1, 0, 3'b000, 3'b000, 10'h155, 10'h0AA, 0));
      vecs.push_back(mk(1, 1, 2, 10'h102, 1, 2, 10'h202, 1, 0, 3'b100, 3'b000, 10'h101, 10'h0AA, 0));
      vecs.push_back(mk(1, 1, 2, 10'h103, 1, 2, 10'h202, 1, 0, 3'b100, 3'b000, 10'h102, 10'h0AA, 0));
      vecs.push_back(mk(1, 1, 2, 10'h104, 1, 2, 10'h202, 1, 0, 3'b100, 3'b000, 10'h103, 10'h0AA, 0));
      vecs.push_back(mk(1, 1, 2, 10'h105, 1, 2, 10'h202, 0, 1, 3'b100, 3'b000, 10'h104, 10'h0AA, 0));
      vecs.push_back(mk(1, 1, 2, 10'h105, 0, 0, 10'h000, 1, 0, 3'b000, 3'b100, 10'h104, 10'h202, 0));
      // Lone MOV request.
      vecs.push_back(mk(1, 0, 0, 10'h000, 1, 0, 10'h033, 0, 1, 3'b100, 3'b000, 10'h105, 10'h202, 0));
      vecs.push_back(mk(1, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 3'b000, 3'b001, 10'h105, 10'h033, 0));
      // Out-of-range PIM, then out-of-range PIM and MOV to the same address (not a conflict).
      vecs.push_back(mk(1, 1, 3, 10'h3FF, 0, 0, 10'h000, 1, 0, 3'b000, 3'b000, 10'h105, 10'h033, 0));
      vecs.push_back(mk(1, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 3'b000, 3'b000, 10'h105, 10'h033, 1));
      vecs.push_back(mk(1, 1, 3, 10'h002, 1, 3, 10'h001, 1, 1, 3'b000, 3'b000, 10'h105, 10'h033, 0));
      vecs.push_back(mk(1, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 3'b000, 3'b000, 10'h105, 10'h033, 1));
      // Two denials, then an out-of-range MOV consumption must clear the starvation count.
      vecs.push_back(mk(1, 1, 1, 10'h011, 1, 1, 10'h022, 1, 0, 3'b000, 3'b000, 10'h105, 10'h033, 0));
      vecs.push_back(mk(1, 1, 1, 10'h012, 1, 1, 10'h022, 1, 0, 3'b010, 3'b000, 10'h011, 10'h033, 0));
      vecs.push_back(mk(1, 1, 1, 10'h013, 0, 0, 10'h000, 1, 0, 3'b010, 3'b000, 10'h012, 10'h033, 0));
      vecs.push_back(mk(1, 0, 0, 10'h000, 1, 3, 10'h024, 0, 1, 3'b010, 3'b000, 10'h013, 10'h033, 0));
      vecs.push_back(mk(1, 1, 0, 10'h031, 1, 0, 10'h041, 1, 0, 3'b000, 3'b000, 10'h013, 10'h033, 1));
      vecs.push_back(mk(1, 1, 0, 10'h032, 1, 0, 10'h041, 1, 0, 3'b001, 3'b000, 10'h031, 10'h033, 0));
      vecs.push_back(mk(1, 1, 0, 10'h033, 1, 0, 10'h041, 1, 0, 3'b001, 3'b000, 10'h032, 10'h033, 0));
      vecs.push_back(mk(1, 1, 0, 10'h034, 1, 0, 10'h041, 1, 0, 3'b001, 3'b000, 10'h033, 10'h033, 0));
      // MOV priority without a MOV request leaves PIM unblocked, then MOV wins the next conflict.
      vecs.push_back(mk(1, 1, 0, 10'h035, 0, 0, 10'h000, 1, 0, 3'b001, 3'b000, 10'h034, 10'h033, 0));
      vecs.push_back(mk(1, 1, 0, 10'h036, 1, 0, 10'h041, 0, 1, 3'b001, 3'b000, 10'h035, 10'h033, 0));
      vecs.push_back(mk(1, 1, 0, 10'h036, 0, 0, 10'h000, 1, 0, 3'b000, 3'b001, 10'h035, 10'h041, 0));
      vecs.push_back(mk(1, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 3'b001, 3'b000, 10'h036, 10'h041, 0));
      // Reach MOV priority, then a mid-run reset must clear outputs and restore PIM priority.
      vecs.push_back(mk(1, 1, 2, 10'h051, 1, 2, 10'h061, 1, 0, 3'b000, 3'b000, 10'h036, 10'h041, 0));
      vecs.push_back(mk(1, 1, 2, 10'h052, 1, 2, 10'h061, 1, 0, 3'b100, 3'b000, 10'h051, 10'h041, 0));
      vecs.push_back(mk(1, 1, 2, 10'h053, 1, 2, 10'h061, 1, 0, 3'b100, 3'b000, 10'h052, 10'h041, 0));
      vecs.push_back(mk(1, 1, 2, 10'h054, 1, 2, 10'h061, 1, 0, 3'b100, 3'b000, 10'h053, 10'h041, 0));
      vecs.push_back(mk(0, 1, 2, 10'h055, 1, 2, 10'h061, 0, 0, 3'b000, 3'b000, 10'h000, 10'h000, 0));
      vecs.push_back(mk(1, 1, 2, 10'h055, 1, 2, 10'h061, 1, 0, 3'b000, 3'b000, 10'h000, 10'h000, 0));
      vecs.push_back(mk(1, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 3'b100, 3'b000, 10'h055, 10'h000, 0));

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
      end

      waitCycles = 0;
      while (scoreboard.size() > 0 && waitCycles < 10) begin
         @(negedge clk);
         waitCycles++;
      end
      #5;
      compCount++;
      if (scoreboard.size() != 0) begin
         failCount++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", scoreboard.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
      $finish;
   end

endmodule
